// File: rtl/path_delay_pkg.sv
// Shared types and helpers for the path delay scheduler: lane state encoding,
// default widths and the effective-delay rule.
package path_delay_pkg;

   localparam int DEF_DELAY_W = 8;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      WAIT  = 2'd2,
      XHOLD = 2'd3
   } lane_state_t;

   // A programmed delay of zero behaves as a one-cycle registered delay.
   function automatic logic [31:0] eff_delay(input logic [31:0] cfg);
      return (cfg == 32'd0) ? 32'd1 : cfg;
   endfunction

endpackage

// File: rtl/path_delay_lane.sv
// One inertial-delay path: schedules each transition of in_bit onto out_sig
// after the rise/fall delay, cancelling pulses that reverse before maturity.
module path_delay_lane
   import path_delay_pkg::*;
#(
   parameter int DELAY_W = DEF_DELAY_W,
   parameter bit INIT    = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELAY_W-1:0] cfg_rise,
   input  logic [DELAY_W-1:0] cfg_fall,
   input  logic               cfg_showcancelled,
   input  logic               cfg_ondetect,
   input  logic               in_bit,
   output logic               out_sig,
   output logic               out_x,
   output logic               cancel_pulse,
   output logic               busy,
   output logic               cancel_evt,
   output lane_state_t        state_dbg
);

   localparam logic [DELAY_W-1:0] ONE = DELAY_W'(1);

   lane_state_t        state, state_n;
   logic [DELAY_W-1:0] cnt, cnt_n;
   logic [DELAY_W-1:0] dly;
   logic               out_q, out_n;
   logic               cancel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         out_q    <= INIT;
         cancel_q <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         out_q    <= out_n;
         cancel_q <= cancel_evt;
      end
   end

   // cnt holds the number of edges left up to and including the maturity edge.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      out_n      = out_q;
      cancel_evt = 1'b0;
      dly        = DELAY_W'(eff_delay(32'(in_bit ? cfg_rise : cfg_fall)));
      case (state)
         IDLE: begin
            if (in_bit != out_q) begin
               if (dly == ONE) begin
                  out_n = in_bit;
               end else begin
                  state_n = PEND;
                  cnt_n   = dly - ONE;
               end
            end
         end
         PEND: begin
            if (cnt == ONE) begin
               // Maturity wins over a reversal arriving in the same cycle.
               out_n   = ~out_q;
               state_n = IDLE;
            end else if (in_bit == out_q) begin
               cancel_evt = 1'b1;
               if (!cfg_showcancelled) begin
                  state_n = IDLE;
               end else if (cfg_ondetect) begin
                  state_n = WAIT;
                  cnt_n   = ONE;
               end else begin
                  state_n = WAIT;
                  cnt_n   = cnt - ONE;
               end
            end else begin
               cnt_n = cnt - ONE;
            end
         end
         WAIT: begin
            if (cnt == ONE) state_n = XHOLD;
            else            cnt_n   = cnt - ONE;
         end
         XHOLD: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign out_sig      = out_q;
   assign out_x        = (state == XHOLD);
   assign busy         = (state != IDLE);
   assign cancel_pulse = cancel_q;
   assign state_dbg    = state;

endmodule

// File: rtl/path_delay_scheduler.sv
// N independent inertial path-delay lanes plus a shared saturating count of
// all cancelled pulses.
module path_delay_scheduler
   import path_delay_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int DELAY_W = DEF_DELAY_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter bit INIT    = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELAY_W-1:0] cfg_rise,
   input  logic [DELAY_W-1:0] cfg_fall,
   input  logic               cfg_showcancelled,
   input  logic               cfg_ondetect,
   input  logic [LANES-1:0]   in_sig,
   output logic [LANES-1:0]   out_sig,
   output logic [LANES-1:0]   out_x,
   output logic [LANES-1:0]   cancel_pulse,
   output logic [LANES-1:0]   busy,
   output logic [CNT_W-1:0]   cancel_cnt
);

   localparam int POP_W = $clog2(LANES + 1);

   logic [LANES-1:0] cancel_evt;
   lane_state_t      lane_state [LANES];
   logic [POP_W-1:0] pop;
   logic [CNT_W:0]   sum;
   logic [CNT_W-1:0] cnt_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      path_delay_lane #(
         .DELAY_W(DELAY_W),
         .INIT   (INIT)
      ) u_lane (
         .clk              (clk),
         .rst              (rst),
         .cfg_rise         (cfg_rise),
         .cfg_fall         (cfg_fall),
         .cfg_showcancelled(cfg_showcancelled),
         .cfg_ondetect     (cfg_ondetect),
         .in_bit           (in_sig[i]),
         .out_sig          (out_sig[i]),
         .out_x            (out_x[i]),
         .cancel_pulse     (cancel_pulse[i]),
         .busy             (busy[i]),
         .cancel_evt       (cancel_evt[i]),
         .state_dbg        (lane_state[i])
      );
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) pop = pop + POP_W'(cancel_evt[i]);
      sum = {1'b0, cnt_q} + (CNT_W + 1)'(pop);
   end

   // Carry out of the add means the count would pass all-ones: clamp there.
   always_ff @(posedge clk) begin
      if (rst)           cnt_q <= '0;
      else if (sum[CNT_W]) cnt_q <= '1;
      else               cnt_q <= sum[CNT_W-1:0];
   end

   assign cancel_cnt = cnt_q;

endmodule

// File: tb/tb_path_delay_scheduler.sv
// Bench for path_delay_scheduler: directed scenarios plus random traffic,
// checked every cycle against an event-time reference model.
module tb_path_delay_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cfg_rise, cfg_fall;
   logic        cfg_showcancelled, cfg_ondetect;
   logic [3:0]  in_sig;
   logic [3:0]  out_sig, out_x, cancel_pulse, busy;
   logic [15:0] cancel_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: per lane a mode plus absolute cycle numbers at which
   // the pending output change or the X flag lands.
   int   m_mode   [4];   // 0 idle, 1 scheduled, 2 cancelled-waiting, 3 x shown
   int   m_mature [4];
   int   m_xat    [4];
   logic [3:0] e_out, e_x, e_cp, e_busy;
   int   e_cnt;

   always #5 clk = ~clk;

   path_delay_scheduler dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_rise         (cfg_rise),
      .cfg_fall         (cfg_fall),
      .cfg_showcancelled(cfg_showcancelled),
      .cfg_ondetect     (cfg_ondetect),
      .in_sig           (in_sig),
      .out_sig          (out_sig),
      .out_x            (out_x),
      .cancel_pulse     (cancel_pulse),
      .busy             (busy),
      .cancel_cnt       (cancel_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_mode[i] = 0; m_mature[i] = 0; m_xat[i] = 0;
      end
      e_out = 4'h0; e_x = 4'h0; e_cp = 4'h0; e_busy = 4'h0; e_cnt = 0;
   endtask

   // Advance the model from cycle t (inputs v, reset r) to cycle t+1.
   task automatic model_step(input int t, input logic [3:0] v, input logic r);
      int d;
      int ncan;
      if (r) begin
         model_reset();
         return;
      end
      ncan = 0;
      e_cp = 4'h0;
      for (int i = 0; i < 4; i++) begin
         case (m_mode[i])
            0: if (v[i] != e_out[i]) begin
                  d = v[i] ? int'(cfg_rise) : int'(cfg_fall);
                  if (d == 0) d = 1;
                  if (d == 1) e_out[i] = v[i];
                  else begin
                     m_mode[i] = 1;
                     m_mature[i] = t + d;
                  end
               end
            1: if (t + 1 == m_mature[i]) begin
                  e_out[i] = ~e_out[i];
                  m_mode[i] = 0;
               end else if (v[i] == e_out[i]) begin
                  e_cp[i] = 1'b1;
                  ncan++;
                  if (!cfg_showcancelled) m_mode[i] = 0;
                  else begin
                     m_mode[i] = 2;
                     m_xat[i] = cfg_ondetect ? t + 2 : m_mature[i];
                  end
               end
            2: if (t + 1 == m_xat[i]) m_mode[i] = 3;
            default: m_mode[i] = 0;
         endcase
      end
      e_cnt = e_cnt + ncan;
      if (e_cnt > 65535) e_cnt = 65535;
      for (int i = 0; i < 4; i++) begin
         e_x[i]    = (m_mode[i] == 3);
         e_busy[i] = (m_mode[i] != 0);
      end
   endtask

   // Check cycle cyc, apply this cycle's inputs, move to the next cycle.
   task automatic drive(input logic [3:0] v, input logic r);
      chk("out_sig", 32'(out_sig), 32'(e_out));
      chk("out_x", 32'(out_x), 32'(e_x));
      chk("cancel_pulse", 32'(cancel_pulse), 32'(e_cp));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("cancel_cnt", 32'(cancel_cnt), 32'(e_cnt));
      in_sig = v;
      rst    = r;
      model_step(cyc, v, r);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_sig = 4'h0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cyc = 0;
   endtask

   task automatic set_cfg(input int r, input int f, input logic sc, input logic od);
      cfg_rise = 8'(r); cfg_fall = 8'(f);
      cfg_showcancelled = sc; cfg_ondetect = od;
   endtask

   initial begin
      logic [3:0] v;
      rst = 1'b1; in_sig = 4'h0;
      set_cfg(3, 5, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);

      // Rise 3 / fall 5 on lane 0
      do_reset();
      chk("reset_out", 32'(out_sig), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      for (int c = 0; c < 32; c++) begin
         if (cyc == 12) chk("t1_before_rise", 32'(out_sig[0]), 32'd0);
         if (cyc == 13) chk("t1_rise", 32'(out_sig[0]), 32'd1);
         if (cyc == 24) chk("t1_before_fall", 32'(out_sig[0]), 32'd1);
         if (cyc == 25) chk("t1_fall", 32'(out_sig[0]), 32'd0);
         if (cyc == 30) chk("t1_cnt", 32'(cancel_cnt), 32'd0);
         drive((cyc >= 10 && cyc < 20) ? 4'h1 : 4'h0, 1'b0);
      end

      // Silent cancellation
      set_cfg(6, 6, 1'b0, 1'b0);
      do_reset();
      for (int c = 0; c < 20; c++) begin
         if (cyc == 12) chk("t2_no_cp_yet", 32'(cancel_pulse[0]), 32'd0);
         if (cyc == 13) chk("t2_cp", 32'(cancel_pulse[0]), 32'd1);
         if (cyc == 13) chk("t2_cnt", 32'(cancel_cnt), 32'd1);
         if (cyc == 14) chk("t2_cp_one_cycle", 32'(cancel_pulse[0]), 32'd0);
         if (cyc == 16) chk("t2_out_stays", 32'(out_sig[0]), 32'd0);
         if (cyc >= 10) chk("t2_no_x", 32'(out_x[0]), 32'd0);
         drive((cyc == 10 || cyc == 11) ? 4'h1 : 4'h0, 1'b0);
      end

      // ondetect
      set_cfg(6, 6, 1'b1, 1'b1);
      do_reset();
      for (int c = 0; c < 20; c++) begin
         if (cyc == 13) chk("t3_cp", 32'(cancel_pulse[0]), 32'd1);
         if (cyc == 13) chk("t3_x_pre", 32'(out_x[0]), 32'd0);
         if (cyc == 14) chk("t3_x", 32'(out_x[0]), 32'd1);
         if (cyc == 14) chk("t3_busy14", 32'(busy[0]), 32'd1);
         if (cyc == 15) chk("t3_x_post", 32'(out_x[0]), 32'd0);
         if (cyc == 15) chk("t3_busy15", 32'(busy[0]), 32'd0);
         drive((cyc == 10 || cyc == 11) ? 4'h1 : 4'h0, 1'b0);
      end

      // onevent, with toggles in the waiting window
      set_cfg(6, 6, 1'b1, 1'b0);
      do_reset();
      for (int c = 0; c < 22; c++) begin
         if (cyc == 14) chk("t4_x14", 32'(out_x[0]), 32'd0);
         if (cyc == 15) chk("t4_x15", 32'(out_x[0]), 32'd0);
         if (cyc == 15) chk("t4_busy15", 32'(busy[0]), 32'd1);
         if (cyc == 16) chk("t4_x16", 32'(out_x[0]), 32'd1);
         if (cyc == 16) chk("t4_busy16", 32'(busy[0]), 32'd1);
         if (cyc == 17) chk("t4_busy17", 32'(busy[0]), 32'd0);
         if (cyc == 17) chk("t4_out", 32'(out_sig[0]), 32'd0);
         drive((cyc == 10 || cyc == 11 || cyc == 13 || cyc == 15) ? 4'h1 : 4'h0, 1'b0);
      end

      // Zero delay, then a simultaneous 4-lane cancel, then saturation
      set_cfg(0, 0, 1'b0, 1'b0);
      do_reset();
      for (int c = 0; c < 26; c++) begin
         if (cyc == 5) chk("t5_zero_pre", 32'(out_sig[0]), 32'd0);
         if (cyc == 6) chk("t5_zero_rise", 32'(out_sig[0]), 32'd1);
         if (cyc == 11) chk("t5_zero_fall", 32'(out_sig[0]), 32'd0);
         if (cyc == 15) set_cfg(3, 3, 1'b0, 1'b0);
         if (cyc == 22) chk("t5_cp_all", 32'(cancel_pulse), 32'hF);
         if (cyc == 22) chk("t5_cnt4", 32'(cancel_cnt), 32'd4);
         if (cyc == 23) chk("t5_cp_clear", 32'(cancel_pulse), 32'h0);
         if (cyc >= 5 && cyc < 10) v = 4'h1;
         else if (cyc == 20) v = 4'hF;
         else v = 4'h0;
         drive(v, 1'b0);
      end
      for (int k = 0; k < 16400; k++) begin
         drive(4'hF, 1'b0);
         drive(4'h0, 1'b0);
      end
      chk("t5_saturated", 32'(cancel_cnt), 32'hFFFF);
      drive(4'h0, 1'b0);
      chk("t5_held", 32'(cancel_cnt), 32'hFFFF);

      // Reset in the middle of a pending rise
      set_cfg(6, 6, 1'b1, 1'b1);
      do_reset();
      for (int c = 0; c < 16; c++) begin
         if (cyc == 12) chk("t6_busy_pre", 32'(busy[0]), 32'd1);
         if (cyc == 13) begin
            chk("t6_out", 32'(out_sig), 32'h0);
            chk("t6_busy", 32'(busy), 32'h0);
            chk("t6_cp", 32'(cancel_pulse), 32'h0);
            chk("t6_cnt", 32'(cancel_cnt), 32'd0);
         end
         drive((cyc >= 10) ? 4'h1 : 4'h0, cyc == 12);
      end

      // Random traffic with shifting configuration and rare resets
      do_reset();
      for (int seg = 0; seg < 20; seg++) begin
         set_cfg($urandom_range(0, 7), $urandom_range(0, 9),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int c = 0; c < 200; c++) begin
            v = in_sig;
            for (int i = 0; i < 4; i++)
               if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
            drive(v, $urandom_range(0, 499) == 0);
         end
      end
      drive(in_sig, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/path_delay_scheduler.md
Name: path_delay_scheduler

Overview:
- Cycle-based emulator of specify-style module path delays for N independent single-bit paths.
- Each input transition is scheduled onto its output after a programmable rise or fall delay in clock cycles.
- Pulses narrower than the delay are cancelled (inertial behaviour). Optional X-flag signalling follows the pulsestyle_onevent, pulsestyle_ondetect and showcancelled semantics.
- Sits between a stimulus/gate-model datapath and its observers in timing-annotated functional simulation and FPGA emulation.

Parameters:
- LANES, 4, number of independent paths.
- DELAY_W, 8, width of the rise/fall delay fields.
- CNT_W, 16, width of the saturating cancellation counter.
- INIT, 0, reset value of every out_sig bit (all lanes).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cfg_rise  input  DELAY_W  0->1 path delay in cycles, shared by all lanes.
- cfg_fall  input  DELAY_W  1->0 path delay in cycles, shared by all lanes.
- cfg_showcancelled  input  1  1 = report cancelled pulses on out_x.
- cfg_ondetect  input  1  1 = ondetect style; 0 = onevent style.
- in_sig  input  LANES  path inputs, synchronous to clk.
- out_sig  output  LANES  delayed path outputs.
- out_x  output  LANES  per-lane "unknown" flag for a cancelled pulse.
- cancel_pulse  output  LANES  1-cycle strobe per lane on every cancellation.
- busy  output  LANES  lane has a pending or waiting event.
- cancel_cnt  output  CNT_W  total cancellations across all lanes, saturating.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: out_sig = {LANES{INIT}}, out_x = 0, cancel_pulse = 0, busy = 0, cancel_cnt = 0; every lane goes to IDLE. Reset mid-operation discards all pending events with no cancel reported.
- Per-lane FSM states: IDLE, PEND, WAIT, XHOLD.
- IDLE:
  - If in_sig != out_sig in cycle T, enter PEND.
  - Latch the delay for that direction (rising uses cfg_rise, falling uses cfg_fall). Effective delay D = max(cfg, 1).
  - out_sig takes the new value visible in cycle T+D, then return to IDLE.
  - cfg changes affect only events scheduled after the change.
- PEND, maturity and cancellation:
  - If in_sig still differs at maturity, out_sig updates.
  - If in_sig returns to out_sig before maturity, the pulse is cancelled: out_sig is unchanged, cancel_pulse = 1 for the next cycle, and cancel_cnt increments (saturating at all-ones).
  - Simultaneous cancels in k lanes in the same cycle add k, clamped.
  - After a cancel:
    - cfg_showcancelled = 0: go to IDLE.
    - showcancelled = 1 and ondetect = 1: go to XHOLD next cycle.
    - showcancelled = 1 and ondetect = 0: go to WAIT.
- WAIT: the counter keeps running to the original maturity cycle, then go to XHOLD. Input changes are ignored in WAIT.
- XHOLD:
  - out_x = 1 for exactly one cycle, then IDLE.
  - IDLE re-evaluates in_sig vs out_sig on the following cycle, so a lingering difference is scheduled one cycle later.
- busy = 1 in PEND, WAIT and XHOLD.
- A maturity and an input reversal in the same cycle count as maturity: the output updates and the reversal is then seen in IDLE next cycle as a new event.
- D = 1 means a 1-cycle registered delay; no pulse can be cancelled at D = 1.
- Delay counters are DELAY_W wide, count down, and never wrap; the all-ones delay is legal.

Decomposition:
- Package path_delay_pkg holds:
  - lane state enum {IDLE, PEND, WAIT, XHOLD};
  - DELAY_W and CNT_W default constants;
  - the function eff_delay(cfg) = (cfg == 0) ? 1 : cfg.
- Sub-module path_delay_lane: one lane FSM, its counter, out_sig/out_x/cancel_pulse/busy, instantiated LANES times by generate.
- The top level holds the cancel_cnt popcount/saturating adder only.

Test Plan:
- Rise/fall delays: rise = 3, fall = 5; lane 0 rises at cycle 10, falls at cycle 20 -> out_sig[0] rises at 13 and falls at 25; cancel_cnt = 0.
- Silent cancellation: rise = 6, showcancelled = 0; 2-cycle high pulse at cycle 10 -> out_sig stays 0, cancel_pulse at 13, cancel_cnt = 1, out_x never set.
- ondetect: rise = 6, showcancelled = 1, ondetect = 1; pulse from 10 to 12 -> cancel_pulse at 13, out_x = 1 only at 14, busy low from 15.
- onevent: same stimulus with ondetect = 0 -> out_x = 1 only at cycle 16 (original maturity) and busy through 16; toggles in cycles 13–15 are ignored.
- Zero delay, simultaneous lanes, saturation: cfg_rise = 0 -> 1-cycle delay; all 4 lanes cancel in one cycle -> cancel_cnt += 4; preload cnt near max -> clamps at 16'hFFFF.
- Reset mid-pending: rst at cycle 12 during a rise = 6 event -> cycle 13: out_sig = INIT, busy = 0, no cancel_pulse, cancel_cnt = 0.
